// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: stall-vector bit positions, stop levels
// and the encoding of the current hazard cause.
package hazard_ctrl_pkg;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    localparam int STALL_EX = 3;
    localparam int STALL_WB = 4;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        HZ_RUN      = 3'd0,
        HZ_MEM_WAIT = 3'd1,
        HZ_EX_WAIT  = 3'd2,
        HZ_BR_FLUSH = 3'd3,
        HZ_LD_USE   = 3'd4,
        HZ_IF_WAIT  = 3'd5
    } hz_state_t;

    // Stop every stage from the PC up to and including stage 'top'.
    function automatic logic [4:0] stall_upto(input int top);
        logic [4:0] v;
        for (int i = 0; i < 5; i++) begin
            v[i] = (i <= top) ? STOP : NO_STOP;
        end
        return v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller: picks one hazard cause per cycle, drives the stop vector,
// tracks wrong-path fetch responses, counts PC-stall cycles and runs a stall watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WDOG_MAX = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_ren,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs2_ren,
    input  logic [4:0]       id_rs2_addr,
    input  logic             ex_is_load,
    input  logic             ex_rd_ena,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_busy,
    input  logic             if_req_valid,
    input  logic             if_rsp_ready,
    input  logic             mem_req_valid,
    input  logic             mem_rsp_ready,
    output logic [4:0]       stall_ctrl,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             if_drop_rsp,
    output logic [2:0]       hz_state,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic             hazard_timeout
);

    localparam int WDOG_W = $clog2(WDOG_MAX + 1);

    hz_state_t         state_q;
    hz_state_t         cause;
    logic              drop_pending;
    logic              set_drop;
    logic              mem_wait;
    logic              fetch_wait;
    logic              ld_use;
    logic              stall_pc;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_sat;
    logic              perf_sat;

    assign mem_wait   = mem_req_valid & ~mem_rsp_ready;
    assign fetch_wait = if_req_valid & ~if_rsp_ready;
    // x0 never carries a real dependency, so it is excluded as a load-use source.
    assign ld_use = ex_is_load & ex_rd_ena & (ex_rd_addr != 5'd0) &
                    ((id_rs1_ren & (id_rs1_addr == ex_rd_addr)) |
                     (id_rs2_ren & (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        cause        = HZ_RUN;
        stall_ctrl   = '0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if_drop_rsp  = 1'b0;
        set_drop     = 1'b0;
        if (mem_wait) begin
            cause      = HZ_MEM_WAIT;
            stall_ctrl = stall_upto(STALL_WB);
        end else if (ex_busy) begin
            // EX/MEM is frozen while MEM/WB keeps moving, which drains a NOP into WB.
            cause      = HZ_EX_WAIT;
            stall_ctrl = stall_upto(STALL_EX);
        end else if (ex_branch_taken) begin
            cause        = HZ_BR_FLUSH;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            set_drop     = fetch_wait;
        end else if (ld_use) begin
            cause        = HZ_LD_USE;
            stall_ctrl   = stall_upto(STALL_IF);
            id_ex_bubble = 1'b1;
        end else if (fetch_wait || drop_pending) begin
            cause        = HZ_IF_WAIT;
            stall_ctrl   = stall_upto(STALL_IF);
            id_ex_bubble = 1'b1;
        end
        // A response to a fetch issued before a taken branch is wrong-path and is discarded.
        if_drop_rsp = drop_pending & if_rsp_ready;
        if (rst == RST_ENABLE) begin
            stall_ctrl   = '0;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            if_drop_rsp  = 1'b0;
            set_drop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= cause;
        end
    end

    assign hz_state = state_q;

    // A new wrong-path fetch takes priority over retiring the previous one.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            drop_pending <= 1'b0;
        end else if (set_drop) begin
            drop_pending <= 1'b1;
        end else if (if_drop_rsp) begin
            drop_pending <= 1'b0;
        end
    end

    assign stall_pc = (stall_ctrl[STALL_PC] == STOP);

    sat_counter #(.W(WDOG_W)) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_pc),
        .clr   (~stall_pc),
        .count (wdog_cnt),
        .sat   (wdog_sat)
    );

    sat_counter #(.W(CNT_W)) u_perf (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_pc & ~perf_sat),
        .clr   (1'b0),
        .count (perf_stall_cnt),
        .sat   (perf_sat)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hazard_timeout <= 1'b0;
        end else if (stall_pc && ((wdog_cnt == WDOG_W'(WDOG_MAX - 1)) || wdog_sat)) begin
            hazard_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

    localparam int CNT_W    = 4;
    localparam int WDOG_MAX = 8;
    localparam int PERF_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_rs1_ren;
    logic [4:0]       id_rs1_addr;
    logic             id_rs2_ren;
    logic [4:0]       id_rs2_addr;
    logic             ex_is_load;
    logic             ex_rd_ena;
    logic [4:0]       ex_rd_addr;
    logic             ex_branch_taken;
    logic             ex_busy;
    logic             if_req_valid;
    logic             if_rsp_ready;
    logic             mem_req_valid;
    logic             mem_rsp_ready;
    logic [4:0]       stall_ctrl;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             if_drop_rsp;
    logic [2:0]       hz_state;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic             hazard_timeout;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .WDOG_MAX(WDOG_MAX)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_ren      (id_rs1_ren),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_ren      (id_rs2_ren),
        .id_rs2_addr     (id_rs2_addr),
        .ex_is_load      (ex_is_load),
        .ex_rd_ena       (ex_rd_ena),
        .ex_rd_addr      (ex_rd_addr),
        .ex_branch_taken (ex_branch_taken),
        .ex_busy         (ex_busy),
        .if_req_valid    (if_req_valid),
        .if_rsp_ready    (if_rsp_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_rsp_ready   (mem_rsp_ready),
        .stall_ctrl      (stall_ctrl),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .if_drop_rsp     (if_drop_rsp),
        .hz_state        (hz_state),
        .perf_stall_cnt  (perf_stall_cnt),
        .hazard_timeout  (hazard_timeout)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Reference model state
    bit m_drop;
    bit m_to;
    int m_wdog;
    int m_perf;
    int m_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic predict(output logic [4:0] e_stall, output logic e_bub, output logic e_fl,
                           output logic e_drop, output logic e_set, output int e_cause);
        bit hit;
        bit waiting;
        hit = ex_is_load && ex_rd_ena && (ex_rd_addr != 0) &&
              ((id_rs1_ren && id_rs1_addr == ex_rd_addr) || (id_rs2_ren && id_rs2_addr == ex_rd_addr));
        waiting = if_req_valid && !if_rsp_ready;
        e_stall = 5'b00000; e_bub = 0; e_fl = 0; e_set = 0; e_cause = 0;
        e_drop  = m_drop && if_rsp_ready;
        if (mem_req_valid && !mem_rsp_ready) begin
            e_stall = 5'b11111; e_cause = 1;
        end else if (ex_busy) begin
            e_stall = 5'b01111; e_cause = 2;
        end else if (ex_branch_taken) begin
            e_bub = 1; e_fl = 1; e_cause = 3; e_set = waiting;
        end else if (hit) begin
            e_stall = 5'b00011; e_bub = 1; e_cause = 4;
        end else if (waiting || m_drop) begin
            e_stall = 5'b00011; e_bub = 1; e_cause = 5;
        end
        if (rst) begin
            e_stall = 5'b00000; e_bub = 0; e_fl = 0; e_drop = 0; e_set = 0;
        end
    endtask

    // One clock cycle: inputs already driven, check combinational outputs mid-cycle,
    // advance the model at the edge, then check registered outputs just after it.
    task automatic step();
        logic [4:0] e_stall;
        logic e_bub, e_fl, e_drop, e_set;
        int e_cause;
        predict(e_stall, e_bub, e_fl, e_drop, e_set, e_cause);
        exp_q.push_back({27'b0, e_stall});
        exp_q.push_back({31'b0, e_bub});
        exp_q.push_back({31'b0, e_fl});
        exp_q.push_back({31'b0, e_drop});
        #3;
        check("stall_ctrl", {27'b0, stall_ctrl}, exp_q.pop_front());
        check("id_ex_bubble", {31'b0, id_ex_bubble}, exp_q.pop_front());
        check("if_id_flush", {31'b0, if_id_flush}, exp_q.pop_front());
        check("if_drop_rsp", {31'b0, if_drop_rsp}, exp_q.pop_front());
        @(posedge clk);
        if (rst) begin
            m_drop = 0; m_to = 0; m_wdog = 0; m_perf = 0; m_state = 0;
        end else begin
            if (e_stall[0]) begin
                if (m_wdog >= WDOG_MAX - 1) m_to = 1;
                m_wdog++;
                if (m_perf < PERF_MAX) m_perf++;
            end else begin
                m_wdog = 0;
            end
            if (e_set) m_drop = 1;
            else if (e_drop) m_drop = 0;
            m_state = e_cause;
        end
        #1;
        check("hz_state", {29'b0, hz_state}, 32'(m_state));
        check("perf_stall_cnt", {28'b0, perf_stall_cnt}, 32'(m_perf));
        check("hazard_timeout", {31'b0, hazard_timeout}, {31'b0, m_to});
    endtask

    task automatic idle();
        rst = 0;
        id_rs1_ren = 0; id_rs1_addr = 0; id_rs2_ren = 0; id_rs2_addr = 0;
        ex_is_load = 0; ex_rd_ena = 0; ex_rd_addr = 0; ex_branch_taken = 0; ex_busy = 0;
        if_req_valid = 0; if_rsp_ready = 0; mem_req_valid = 0; mem_rsp_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_is_load = 1; ex_rd_ena = 1; ex_rd_addr = rd;
        id_rs2_ren = 1; id_rs2_addr = rd;
    endtask

    initial begin
        m_drop = 0; m_to = 0; m_wdog = 0; m_perf = 0; m_state = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Load-use on rs2, then the load leaves EX; rd=x0 never stalls
        load_use(5'd5); step();
        idle(); step();
        load_use(5'd0); step();
        idle(); step();

        // Data-memory wait hides a taken branch until the release cycle
        mem_req_valid = 1; mem_rsp_ready = 0; ex_branch_taken = 1;
        repeat (3) step();
        mem_rsp_ready = 1; step();
        idle(); step();

        // Multi-cycle EX outranks a concurrent load-use
        load_use(5'd7); ex_busy = 1;
        repeat (4) step();
        idle(); step();

        // Branch while a fetch is outstanding: that response is dropped, the next is kept
        ex_branch_taken = 1; if_req_valid = 1; if_rsp_ready = 0; step();
        ex_branch_taken = 0; step();
        if_rsp_ready = 1; step();
        step();
        idle(); step();

        // Watchdog and stall counter, including counter saturation
        do_reset();
        if_req_valid = 1; if_rsp_ready = 0;
        repeat (10) step();
        repeat (8) step();
        idle(); step();
        do_reset();

        // Reset in the middle of a memory wait with a wrong-path fetch pending
        ex_branch_taken = 1; if_req_valid = 1; if_rsp_ready = 0; step();
        idle(); mem_req_valid = 1; step();
        step();
        rst = 1; step();
        idle(); step();
        step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            mem_req_valid   = ($urandom_range(0, 3) == 0);
            mem_rsp_ready   = ($urandom_range(0, 1) == 1);
            ex_busy         = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_is_load      = ($urandom_range(0, 1) == 1);
            ex_rd_ena       = ($urandom_range(0, 3) != 0);
            ex_rd_addr      = 5'($urandom_range(0, 3));
            id_rs1_ren      = ($urandom_range(0, 1) == 1);
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_ren      = ($urandom_range(0, 1) == 1);
            id_rs2_addr     = 5'($urandom_range(0, 3));
            if_req_valid    = ($urandom_range(0, 1) == 1);
            if_rsp_ready    = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
